// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared types, ML class codes and rank helper for the circuit breaker
package cb_pkg;

  typedef enum logic [1:0] {
    CB_NORMAL   = 2'b00,
    CB_THROTTLE = 2'b01,
    CB_WIDEN    = 2'b10,
    CB_PAUSE    = 2'b11
  } cb_mode_t;

  typedef enum logic [1:0] {
    SRC_ML   = 2'd0,
    SRC_AN   = 2'd1,
    SRC_HOST = 2'd2
  } cb_src_t;

  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_FLASH  = 3'd3;
  localparam logic [2:0] CLS_IMBAL  = 3'd4;
  localparam logic [2:0] CLS_QSTUFF = 3'd5;

  typedef struct packed {
    logic       valid;
    cb_mode_t   mode;
    logic [7:0] conf;
    cb_src_t    src;
  } cb_req_t;

  // Severity order differs from the mode encoding (THROTTLE outranks WIDEN).
  function automatic logic [1:0] cb_rank(cb_mode_t m);
    case (m)
      CB_PAUSE:    return 2'd3;
      CB_THROTTLE: return 2'd2;
      CB_WIDEN:    return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cb_req_select.sv
// rtl/cb_req_select.sv - one-cycle three-source request selector with loser-drop flag
module cb_req_select
  import cb_pkg::*;
(
  input  logic       ml_valid,
  input  logic [2:0] ml_class,
  input  logic [7:0] ml_conf,
  input  logic       an_valid,
  input  logic [1:0] an_mode,
  input  logic [7:0] an_conf,
  input  logic       host_valid,
  input  logic [1:0] host_mode,
  input  logic [7:0] host_conf,
  output cb_req_t    win,
  output logic       loser_drop
);

  cb_req_t ml_req, an_req, host_req;

  always_comb begin
    ml_req       = '0;
    ml_req.src   = SRC_ML;
    ml_req.conf  = ml_conf;
    case (ml_class)
      CLS_NORMAL: begin ml_req.valid = ml_valid; ml_req.mode = CB_NORMAL;   end
      CLS_FLASH:  begin ml_req.valid = ml_valid; ml_req.mode = CB_PAUSE;    end
      CLS_IMBAL:  begin ml_req.valid = ml_valid; ml_req.mode = CB_WIDEN;    end
      CLS_QSTUFF: begin ml_req.valid = ml_valid; ml_req.mode = CB_THROTTLE; end
      default:    ml_req.valid = 1'b0;
    endcase

    an_req.valid   = an_valid && (an_mode != 2'b00);
    an_req.mode    = cb_mode_t'(an_mode);
    an_req.conf    = an_conf;
    an_req.src     = SRC_AN;

    host_req.valid = host_valid;
    host_req.mode  = cb_mode_t'(host_mode);
    host_req.conf  = host_conf;
    host_req.src   = SRC_HOST;
  end

  always_comb begin
    win        = an_req;
    loser_drop = 1'b0;
    if (host_req.valid) begin
      win        = host_req;
      loser_drop = ml_req.valid || an_req.valid;
    end else if (ml_req.valid && an_req.valid) begin
      win        = (cb_rank(an_req.mode) > cb_rank(ml_req.mode)) ? an_req : ml_req;
      loser_drop = 1'b1;
    end else if (ml_req.valid) begin
      win = ml_req;
    end
  end

endmodule

// File: rtl/cb_arbiter.sv
// rtl/cb_arbiter.sv - circuit-breaker arbiter: trip/reload/heal/holdoff FSM and CB outputs
module cb_arbiter
  import cb_pkg::*;
#(
  parameter int MIN_CONF    = 4,
  parameter int HOLDOFF_CYC = 16,
  parameter int CD_W        = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ml_valid,
  input  logic [2:0]      ml_class,
  input  logic [7:0]      ml_conf,
  input  logic            an_valid,
  input  logic [1:0]      an_mode,
  input  logic [7:0]      an_conf,
  input  logic            host_valid,
  input  logic [1:0]      host_mode,
  input  logic [7:0]      host_conf,
  output logic [1:0]      cb_mode,
  output logic            cb_active,
  output logic [CD_W-1:0] cb_countdown,
  output logic [3:0]      throttle_div,
  output logic [2:0]      spread_guard,
  output logic            host_lock,
  output logic            trip_pulse,
  output logic            heal_pulse,
  output logic [7:0]      trip_cnt,
  output logic [7:0]      drop_cnt
);

  localparam int          HW         = $clog2(HOLDOFF_CYC + 1);
  localparam logic [7:0]  MIN_CONF_B = 8'(MIN_CONF);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLDOFF} state_t;

  state_t          state;
  cb_mode_t        mode_r;
  logic [CD_W-1:0] cd_r;
  logic [3:0]      thr_r;
  logic [2:0]      spr_r;
  logic [HW-1:0]   hold_r;

  cb_req_t   win;
  logic      loser_drop;

  cb_req_select u_sel (
    .ml_valid   (ml_valid),
    .ml_class   (ml_class),
    .ml_conf    (ml_conf),
    .an_valid   (an_valid),
    .an_mode    (an_mode),
    .an_conf    (an_conf),
    .host_valid (host_valid),
    .host_mode  (host_mode),
    .host_conf  (host_conf),
    .win        (win),
    .loser_drop (loser_drop)
  );

  logic            is_clear, is_trip, trip_ok, trip_rej, clear_ok, clear_rej;
  logic [1:0]      drop_inc;
  logic [8:0]      drop_sum;
  logic [CD_W-1:0] reload;

  always_comb begin
    is_clear  = win.valid && (win.mode == CB_NORMAL);
    is_trip   = win.valid && (win.mode != CB_NORMAL) && (win.conf >= MIN_CONF_B);
    trip_ok   = is_trip && ((state == ST_IDLE) ||
                            (state == ST_ACTIVE && cb_rank(win.mode) >= cb_rank(mode_r)) ||
                            (state == ST_HOLDOFF && win.mode == CB_PAUSE));
    trip_rej  = is_trip && !trip_ok;
    // ML CLEAR cannot override a host-owned breaker; host CLEAR always can.
    clear_ok  = is_clear && (state == ST_ACTIVE) && (win.src == SRC_HOST || !host_lock);
    clear_rej = is_clear && (state == ST_ACTIVE) && (win.src != SRC_HOST) && host_lock;
    drop_inc  = {1'b0, loser_drop} + {1'b0, trip_rej} + {1'b0, clear_rej};
    drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_inc};
    reload    = CD_W'({win.conf, 1'b0});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_r     <= CB_NORMAL;
      cd_r       <= '0;
      thr_r      <= '0;
      spr_r      <= '0;
      hold_r     <= '0;
      host_lock  <= 1'b0;
      trip_pulse <= 1'b0;
      heal_pulse <= 1'b0;
      trip_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      trip_pulse <= 1'b0;
      heal_pulse <= 1'b0;
      drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (trip_ok) begin
        mode_r <= win.mode;
        cd_r   <= reload;
        if (win.mode == CB_THROTTLE) thr_r <= win.conf[7:4];
        if (win.mode == CB_WIDEN)    spr_r <= win.conf[7:5];
        if (win.src == SRC_HOST)     host_lock <= 1'b1;
        else if (state != ST_ACTIVE) host_lock <= 1'b0;
        if (state != ST_ACTIVE) begin
          state      <= ST_ACTIVE;
          trip_pulse <= 1'b1;
          if (trip_cnt != 8'hFF) trip_cnt <= trip_cnt + 8'd1;
        end
      end else if (clear_ok) begin
        state     <= ST_IDLE;
        mode_r    <= CB_NORMAL;
        cd_r      <= '0;
        host_lock <= 1'b0;
      end else begin
        case (state)
          ST_ACTIVE: begin
            if (cd_r == CD_W'(1)) begin
              state      <= ST_HOLDOFF;
              mode_r     <= CB_NORMAL;
              cd_r       <= '0;
              host_lock  <= 1'b0;
              heal_pulse <= 1'b1;
              hold_r     <= HW'(HOLDOFF_CYC);
            end else begin
              cd_r <= cd_r - CD_W'(1);
            end
          end
          ST_HOLDOFF: begin
            if (hold_r == HW'(1)) state  <= ST_IDLE;
            else                  hold_r <= hold_r - HW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign cb_mode      = mode_r;
  assign cb_active    = (mode_r != CB_NORMAL);
  assign cb_countdown = cd_r;
  assign throttle_div = (mode_r == CB_THROTTLE) ? thr_r : 4'd0;
  assign spread_guard = (mode_r == CB_WIDEN)    ? spr_r : 3'd0;

endmodule

// File: tb/tb_cb_arbiter.sv
// tb/tb_cb_arbiter.sv - self-checking bench for cb_arbiter (vector table, corner sequences, random vs model)
module tb_cb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ml_valid, an_valid, host_valid;
  logic [2:0] ml_class;
  logic [7:0] ml_conf, an_conf, host_conf;
  logic [1:0] an_mode, host_mode;
  logic [1:0] cb_mode;
  logic       cb_active, host_lock, trip_pulse, heal_pulse;
  logic [8:0] cb_countdown;
  logic [3:0] throttle_div;
  logic [2:0] spread_guard;
  logic [7:0] trip_cnt, drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cb_arbiter dut (
    .clk(clk), .rst(rst),
    .ml_valid(ml_valid), .ml_class(ml_class), .ml_conf(ml_conf),
    .an_valid(an_valid), .an_mode(an_mode), .an_conf(an_conf),
    .host_valid(host_valid), .host_mode(host_mode), .host_conf(host_conf),
    .cb_mode(cb_mode), .cb_active(cb_active), .cb_countdown(cb_countdown),
    .throttle_div(throttle_div), .spread_guard(spread_guard), .host_lock(host_lock),
    .trip_pulse(trip_pulse), .heal_pulse(heal_pulse),
    .trip_cnt(trip_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: state 0=idle 1=active 2=holdoff, modes as 0..3
  int m_state, m_mode, m_cd, m_thr, m_spr, m_lock, m_tp, m_hp, m_trips, m_drops, m_hold;

  function automatic int rank_of(int m);
    case (m)
      3: return 3;
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int vm[3]; int vc[3]; bit vv[3];
    int best, best_score, score, n, add;
    bit done;
    m_tp = 0; m_hp = 0;
    if (rst) begin
      m_state = 0; m_mode = 0; m_cd = 0; m_thr = 0; m_spr = 0; m_lock = 0;
      m_trips = 0; m_drops = 0; m_hold = 0;
      return;
    end
    vv[0] = ml_valid && (ml_class inside {3'd0, 3'd3, 3'd4, 3'd5});
    vm[0] = (ml_class == 3) ? 3 : (ml_class == 5) ? 1 : (ml_class == 4) ? 2 : 0;
    vc[0] = ml_conf;
    vv[1] = an_valid && (an_mode != 0); vm[1] = an_mode;   vc[1] = an_conf;
    vv[2] = host_valid;                 vm[2] = host_mode; vc[2] = host_conf;
    n = 0; best = -1; best_score = -1;
    for (int i = 0; i < 3; i++) begin
      if (vv[i]) begin
        n++;
        score = (i == 2) ? 100 : rank_of(vm[i]) * 2 + ((i == 0) ? 1 : 0);
        if (score > best_score) begin best_score = score; best = i; end
      end
    end
    add = (n > 1) ? 1 : 0;
    done = 0;
    if (best >= 0) begin
      if (vm[best] == 0) begin
        if (m_state == 1) begin
          if (best == 2 || m_lock == 0) begin
            m_state = 0; m_mode = 0; m_cd = 0; m_lock = 0; done = 1;
          end else add++;
        end
      end else if (vc[best] >= 4) begin
        if (m_state == 0 || (m_state == 1 && rank_of(vm[best]) >= rank_of(m_mode)) ||
            (m_state == 2 && vm[best] == 3)) begin
          if (m_state != 1) begin
            m_tp = 1; m_lock = 0;
            m_trips = (m_trips < 255) ? m_trips + 1 : 255;
          end
          if (best == 2) m_lock = 1;
          m_mode = vm[best]; m_cd = 2 * vc[best];
          if (m_mode == 1) m_thr = vc[best] / 16;
          if (m_mode == 2) m_spr = vc[best] / 32;
          m_state = 1; done = 1;
        end else add++;
      end
    end
    if (!done) begin
      if (m_state == 1) begin
        if (m_cd == 1) begin
          m_state = 2; m_mode = 0; m_cd = 0; m_lock = 0; m_hp = 1; m_hold = 16;
        end else m_cd--;
      end else if (m_state == 2) begin
        if (m_hold == 1) m_state = 0; else m_hold--;
      end
    end
    m_drops = (m_drops + add > 255) ? 255 : m_drops + add;
  endtask

  task automatic check_model();
    chk("model_mode", cb_mode, m_mode);
    chk("model_active", cb_active, (m_mode != 0) ? 1 : 0);
    chk("model_countdown", cb_countdown, m_cd);
    chk("model_throttle_div", throttle_div, (m_mode == 1) ? m_thr : 0);
    chk("model_spread_guard", spread_guard, (m_mode == 2) ? m_spr : 0);
    chk("model_host_lock", host_lock, m_lock);
    chk("model_trip_pulse", trip_pulse, m_tp);
    chk("model_heal_pulse", heal_pulse, m_hp);
    chk("model_trip_cnt", trip_cnt, m_trips);
    chk("model_drop_cnt", drop_cnt, m_drops);
  endtask

  task automatic idle_inputs();
    ml_valid = 0; ml_class = 0; ml_conf = 0;
    an_valid = 0; an_mode = 0; an_conf = 0;
    host_valid = 0; host_mode = 0; host_conf = 0;
  endtask

  task automatic set_ml(int c, int f);   ml_valid = 1; ml_class = 3'(c); ml_conf = 8'(f);     endtask
  task automatic set_an(int m, int f);   an_valid = 1; an_mode = 2'(m); an_conf = 8'(f);      endtask
  task automatic set_host(int m, int f); host_valid = 1; host_mode = 2'(m); host_conf = 8'(f); endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle_inputs();
    check_model();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  typedef struct {
    int ml_c, ml_f, an_m, an_f, h_m, h_f;
    int e_mode, e_cd, e_thr, e_spr, e_drop, e_trip, e_lock;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // ml_c/an_m/h_m of -1 means that source is idle
    vecs[0]  = '{ 5, 60,  2, 64, -1,   0,  1, 120, 3, 0, 1, 1, 0};
    vecs[1]  = '{-1,  0,  2, 64, -1,   0,  1, 119, 3, 0, 2, 1, 0};
    vecs[2]  = '{ 4, 64, -1,  0, -1,   0,  1, 118, 3, 0, 3, 1, 0};
    vecs[3]  = '{ 3,  3, -1,  0, -1,   0,  1, 117, 3, 0, 3, 1, 0};
    vecs[4]  = '{ 1,100, -1,  0, -1,   0,  1, 116, 3, 0, 3, 1, 0};
    vecs[5]  = '{ 3, 50, -1,  0, -1,   0,  3, 100, 0, 0, 3, 1, 0};
    vecs[6]  = '{-1,  0, -1,  0,  3, 200,  3, 400, 0, 0, 3, 1, 1};
    vecs[7]  = '{ 0, 90, -1,  0, -1,   0,  3, 399, 0, 0, 4, 1, 1};
    vecs[8]  = '{ 3, 20, -1,  0, -1,   0,  3,  40, 0, 0, 4, 1, 1};
    vecs[9]  = '{ 3, 60, -1,  0,  0,   0,  0,   0, 0, 0, 5, 1, 0};
    vecs[10] = '{-1,  0,  2, 64, -1,   0,  2, 128, 0, 2, 5, 2, 0};
    vecs[11] = '{ 5, 40, -1,  0, -1,   0,  1,  80, 2, 0, 5, 2, 0};
    vecs[12] = '{ 0, 90,  1,100, -1,   0,  1, 200, 6, 0, 6, 2, 0};
    vecs[13] = '{ 0, 90, -1,  0, -1,   0,  0,   0, 0, 0, 6, 2, 0};
    vecs[14] = '{-1,  0, -1,  0, -1,   0,  0,   0, 0, 0, 6, 2, 0};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_mode", cb_mode, 0);
    chk("reset_countdown", cb_countdown, 0);
    chk("reset_trip_cnt", trip_cnt, 0);
    chk("reset_drop_cnt", drop_cnt, 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].ml_c >= 0) set_ml(vecs[i].ml_c, vecs[i].ml_f);
      if (vecs[i].an_m >= 0) set_an(vecs[i].an_m, vecs[i].an_f);
      if (vecs[i].h_m >= 0)  set_host(vecs[i].h_m, vecs[i].h_f);
      tick();
      chk($sformatf("vec%0d_mode", i), cb_mode, vecs[i].e_mode);
      chk($sformatf("vec%0d_countdown", i), cb_countdown, vecs[i].e_cd);
      chk($sformatf("vec%0d_throttle", i), throttle_div, vecs[i].e_thr);
      chk($sformatf("vec%0d_spread", i), spread_guard, vecs[i].e_spr);
      chk($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].e_drop);
      chk($sformatf("vec%0d_trip", i), trip_cnt, vecs[i].e_trip);
      chk($sformatf("vec%0d_lock", i), host_lock, vecs[i].e_lock);
    end

    // Full self-heal then holdoff boundary: last holdoff cycle rejects, next accepts
    do_reset();
    set_ml(3, 60); tick();
    chk("heal_trip_mode", cb_mode, 3);
    chk("heal_trip_cd", cb_countdown, 120);
    chk("heal_trip_pulse", trip_pulse, 1);
    repeat (119) tick();
    chk("heal_cd_one", cb_countdown, 1);
    chk("heal_still_pause", cb_mode, 3);
    tick();
    chk("heal_mode", cb_mode, 0);
    chk("heal_pulse", heal_pulse, 1);
    repeat (15) tick();
    set_an(2, 64); tick();
    chk("holdoff_last_reject_mode", cb_mode, 0);
    chk("holdoff_last_reject_drop", drop_cnt, 1);
    set_an(2, 64); tick();
    chk("after_holdoff_mode", cb_mode, 2);
    chk("after_holdoff_trip_cnt", trip_cnt, 2);

    // Short trip, heal at cycle 20, holdoff rejects WIDEN but takes PAUSE
    do_reset();
    set_ml(3, 10); tick();
    chk("short_cd", cb_countdown, 20);
    repeat (20) tick();
    chk("short_heal", heal_pulse, 1);
    repeat (4) tick();
    set_ml(4, 64); tick();
    chk("holdoff_widen_mode", cb_mode, 0);
    chk("holdoff_widen_drop", drop_cnt, 1);
    set_ml(3, 10); tick();
    chk("holdoff_pause_mode", cb_mode, 3);
    chk("holdoff_pause_pulse", trip_pulse, 1);
    chk("holdoff_pause_trips", trip_cnt, 2);

    // Reset mid-PAUSE
    tick();
    rst = 1; tick(); rst = 0;
    chk("midreset_mode", cb_mode, 0);
    chk("midreset_active", cb_active, 0);
    chk("midreset_cd", cb_countdown, 0);
    chk("midreset_trips", trip_cnt, 0);

    // Counter saturation
    set_host(3, 200); tick();
    for (int i = 0; i < 260; i++) begin set_an(2, 64); tick(); end
    chk("drop_saturate", drop_cnt, 255);
    chk("sat_cd", cb_countdown, 140);
    set_host(0, 0); tick();
    for (int i = 0; i < 260; i++) begin
      set_host(3, 4); tick();
      set_host(0, 0); tick();
    end
    chk("trip_saturate", trip_cnt, 255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_ml(int'($urandom_range(0, 7)),
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0)
        set_an(int'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
      if ($urandom_range(0, 39) == 0)
        set_host(int'($urandom_range(0, 3)), int'($urandom_range(0, 80)));
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cb_arbiter.md
Name: cb_arbiter

Overview:
- Owns the order book's circuit breaker (CB). Takes trip/clear requests from three sources: the ML inference engine, the anomaly detector and the host. Arbitrates them by severity.
- Converts the winning request into the registered CB mode, countdown, throttle divider and spread guard, which drive the order book's CB enforcement.
- Self-heals on countdown expiry, then applies a holdoff window against re-trip chatter.
- Replaces the direct ml_valid/ml_class/ml_confidence path into the order book.

Parameters:
- MIN_CONF, 4, trip requests with conf < MIN_CONF are ignored (guarantees countdown >= 8).
- HOLDOFF_CYC, 16, cycles after self-heal during which only PAUSE requests are accepted.
- CD_W, 9, countdown width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ml_valid  in  1  ML result strobe.
- ml_class  in  3  ML class: 0=NORMAL, 3=FLASH_CRASH, 4=IMBALANCE, 5=QUOTE_STUFF; others ignored.
- ml_conf  in  8  ML confidence.
- an_valid  in  1  anomaly detector strobe.
- an_mode  in  2  requested mode (00 ignored).
- an_conf  in  8  anomaly confidence.
- host_valid  in  1  host command strobe.
- host_mode  in  2  host mode (00 = clear).
- host_conf  in  8  host confidence.
- cb_mode  out  2  00 NORMAL, 01 THROTTLE, 10 WIDEN, 11 PAUSE.
- cb_active  out  1  cb_mode != 00.
- cb_countdown  out  CD_W  remaining cycles.
- throttle_div  out  4  conf>>4 of the accepted THROTTLE request.
- spread_guard  out  3  conf>>5 of the accepted WIDEN request.
- host_lock  out  1  current mode was set by the host.
- trip_pulse  out  1  one-cycle pulse on entry to ACTIVE from IDLE/HOLDOFF.
- heal_pulse  out  1  one-cycle pulse on countdown expiry.
- trip_cnt  out  8  saturating count of trips.
- drop_cnt  out  8  saturating count of rejected requests.

Behaviour:
- Reset (rst=1 at a posedge): all outputs 0; state IDLE. Reset mid-trip drops the CB in the next cycle.
- Class mapping for ML requests: 3→PAUSE, 5→THROTTLE, 4→WIDEN, 0→CLEAR; classes 1, 2, 6, 7 are ignored and not counted as drops.
- Rank: PAUSE=3, THROTTLE=2, WIDEN=1, NORMAL=0.
- Candidate selection in one cycle:
  - A host request wins outright.
  - Otherwise the higher-rank request wins.
  - On equal rank, ML beats anomaly.
  - The loser of a simultaneous pair increments drop_cnt.
- Trip acceptance:
  - Requires conf >= MIN_CONF.
  - Rank >= current rank is accepted: it reloads countdown = {conf,1'b0} (2*conf) and the mode parameters.
  - Lower rank while ACTIVE is rejected; drop_cnt += 1.
- Latency: request sampled at posedge N; outputs updated at posedge N (visible in cycle N+1). ML→order-book effect is therefore 1 cycle from this block.
- States:
  - IDLE: an accepted trip → ACTIVE, trip_pulse, trip_cnt += 1.
  - ACTIVE: countdown decrements by 1 per cycle. An accepted request reloads it that cycle with no decrement. When countdown==1 and no accepted request → NORMAL, countdown 0, heal_pulse, then HOLDOFF.
  - ACTIVE, ML CLEAR: immediate NORMAL → IDLE, no heal_pulse. Ignored (drop_cnt += 1) if host_lock=1.
  - ACTIVE, host CLEAR: always clears → IDLE and drops host_lock.
  - HOLDOFF: internal counter runs HOLDOFF_CYC cycles, then → IDLE. A PAUSE request → ACTIVE with trip_pulse. THROTTLE/WIDEN requests are rejected (drop_cnt += 1).
- host_lock: set when the host trips; cleared by host CLEAR, expiry or reset. While host_lock=1, ML/anomaly requests of equal or higher rank may still reload countdown and parameters; host_lock stays 1.
- throttle_div and spread_guard hold their last accepted values and read as 0 whenever cb_mode is not THROTTLE or WIDEN respectively.
- Counters saturate at 255 and never wrap.
- A CLEAR arriving in the same cycle as a trip: the host term decides. Without a host request, a trip beats an ML CLEAR.

Decomposition:
- Shared package cb_pkg:
  - cb_mode_t enum (NORMAL/THROTTLE/WIDEN/PAUSE).
  - ML class constants (CLS_NORMAL=0, CLS_FLASH=3, CLS_IMBAL=4, CLS_QSTUFF=5).
  - Rank function.
  - cb_req_t struct {valid, mode, conf, src}.
- Sub-module cb_req_select: combinational three-source priority selector producing the winning cb_req_t plus a loser-drop flag. The FSM, counters and registers stay in cb_arbiter.

Test Plan:
- ML class 3, conf 60 → next cycle cb_mode=11, countdown=120, trip_pulse=1. After 120 idle cycles: cb_mode=00, heal_pulse=1. Then 16 cycles of HOLDOFF.
- ML class 5 conf 60 and an_mode=10 (WIDEN) conf 64 in the same cycle → cb_mode=01, throttle_div=3, drop_cnt=1.
- Active WIDEN (conf 64, spread_guard=2), then ML class 5 conf 40 → THROTTLE, countdown=80. A following an_mode=10 request → rejected, drop_cnt+1, countdown keeps decrementing.
- Host mode 11, conf 200 → host_lock=1, countdown=400. Then ML class 0 → ignored, drop_cnt+1. Then host_mode=00 → cb_mode=00 next cycle, no heal_pulse.
- Self-heal with conf 10 → heal at cycle 20. ML class 4 conf 64 at HOLDOFF cycle 5 → rejected. ML class 3 conf 10 at HOLDOFF cycle 6 → PAUSE, trip_cnt=2.
- ML class 3 conf 3 (< MIN_CONF) → no change. rst asserted mid-PAUSE → all outputs 0 next cycle, trip_cnt=0.
